// File: rtl/histogram_frame_controller_pkg.sv
// Shared definitions for the histogram frame controller.
// Holds the sequencer state encoding and the size derivations (bin count,
// table count, count/CDF width, counter widths) used by the controller.
// No ports.
package hist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_TABLE,
    ST_RUN_TABLE,
    ST_READOUT,
    ST_DONE
  } state_t;

  function automatic int num_bins(input int pixel_width);
    return 2 ** pixel_width;
  endfunction

  function automatic int num_tables(input int width, input int height, input int table_size);
    return (width * height) / table_size;
  endfunction

  // Wide enough to hold a count equal to every pixel of the frame.
  function automatic int hist_dw(input int width, input int height);
    return $clog2(width * height + 1);
  endfunction

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/histogram_frame_controller_if.sv
// Bus bundle around the histogram frame controller.
// Groups the frame/table handshakes, the histogram generator RAM channel,
// the histogram RAM port and the bin record stream.
//   slave  : controller view (drives busy, table_*, gen_start/is_first,
//            gen_rdata, ram_*, hist_valid/bin/count/cdf, frame_done)
//   master : environment view (drives frame_start, table_valid, gen_addr,
//            gen_we, gen_wdata, ram_rdata, hist_ready)
interface histogram_frame_controller_if #(
  parameter int HIST_AW = 8,
  parameter int HIST_DW = 17
);
  logic               frame_start;
  logic               busy;
  logic               table_valid;
  logic               table_ready;
  logic               table_done;
  logic               gen_start;
  logic               gen_is_first;
  logic [HIST_AW-1:0] gen_addr;
  logic               gen_we;
  logic [HIST_DW-1:0] gen_wdata;
  logic [HIST_DW-1:0] gen_rdata;
  logic [HIST_AW-1:0] ram_addr;
  logic               ram_we;
  logic [HIST_DW-1:0] ram_wdata;
  logic [HIST_DW-1:0] ram_rdata;
  logic               hist_valid;
  logic               hist_ready;
  logic [HIST_AW-1:0] hist_bin;
  logic [HIST_DW-1:0] hist_count;
  logic [HIST_DW-1:0] hist_cdf;
  logic               frame_done;

  modport slave (
    input  frame_start, table_valid, gen_addr, gen_we, gen_wdata, ram_rdata, hist_ready,
    output busy, table_ready, table_done, gen_start, gen_is_first, gen_rdata,
           ram_addr, ram_we, ram_wdata, hist_valid, hist_bin, hist_count, hist_cdf, frame_done
  );

  modport master (
    output frame_start, table_valid, gen_addr, gen_we, gen_wdata, ram_rdata, hist_ready,
    input  busy, table_ready, table_done, gen_start, gen_is_first, gen_rdata,
           ram_addr, ram_we, ram_wdata, hist_valid, hist_bin, hist_count, hist_cdf, frame_done
  );
endinterface

// File: rtl/histogram_ram_port_mux.sv
// Selects who drives the single histogram RAM port for the current state.
// Ports:
//   state_i      sequencer state
//   cnt_i        shared clear/readout bin counter
//   gen_addr_i   generator address   gen_we_i  generator write enable
//   gen_wdata_i  generator write data
//   ram_addr_o / ram_we_o / ram_wdata_o  histogram RAM port
module histogram_ram_port_mux
  import hist_ctrl_pkg::*;
#(
  parameter int HIST_AW = 8,
  parameter int HIST_DW = 17
) (
  input  state_t             state_i,
  input  logic [HIST_AW-1:0] cnt_i,
  input  logic [HIST_AW-1:0] gen_addr_i,
  input  logic               gen_we_i,
  input  logic [HIST_DW-1:0] gen_wdata_i,
  output logic [HIST_AW-1:0] ram_addr_o,
  output logic               ram_we_o,
  output logic [HIST_DW-1:0] ram_wdata_o
);

  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    case (state_i)
      ST_CLEAR: begin
        ram_addr_o = cnt_i;
        ram_we_o   = 1'b1;
      end
      ST_RUN_TABLE: begin
        ram_addr_o  = gen_addr_i;
        ram_we_o    = gen_we_i;
        ram_wdata_o = gen_wdata_i;
      end
      ST_READOUT: ram_addr_o = cnt_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/histogram_frame_controller.sv
// Frame-level sequencer and sole owner of the histogram RAM.
// Per frame: clear every bin, hand each IDCT table to the histogram
// generator (which owns the RAM port while it runs), then stream each bin's
// count and running CDF downstream.
// Ports:
//   clk  rising-edge clock        rst  synchronous active-high reset
//   hif  controller side of the frame/table/generator/RAM/record bundle
//
// state       | meaning
// ST_IDLE     | waiting for frame_start
// ST_CLEAR    | writing 0 to every bin, one per cycle
// ST_WAIT_TABLE | waiting for a table from the IDCT
// ST_RUN_TABLE  | generator owns the RAM for 2*TABLE_SIZE cycles
// ST_READOUT  | streaming bin count + CDF records
// ST_DONE     | one-cycle frame_done, counters cleared
module histogram_frame_controller
  import hist_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_WIDTH  = 8,
  parameter int TABLE_SIZE   = 64,
  parameter int HIST_AW      = PIXEL_WIDTH,
  parameter int HIST_DW      = hist_dw(IMAGE_WIDTH, IMAGE_HEIGHT)
) (
  input logic clk,
  input logic rst,
  histogram_frame_controller_if.slave hif
);

  localparam int NUM_BINS   = num_bins(PIXEL_WIDTH);
  localparam int NUM_TABLES = num_tables(IMAGE_WIDTH, IMAGE_HEIGHT, TABLE_SIZE);
  localparam int RUN_LEN    = 2 * TABLE_SIZE;
  localparam int RUN_W      = cnt_width(RUN_LEN);
  localparam int TBL_W      = cnt_width(NUM_TABLES);

  localparam logic [HIST_AW-1:0] LAST_BIN = HIST_AW'(NUM_BINS - 1);
  localparam logic [RUN_W-1:0]   LAST_RUN = RUN_W'(RUN_LEN - 1);
  localparam logic [TBL_W-1:0]   LAST_TBL = TBL_W'(NUM_TABLES - 1);

  state_t             state_q, state_d;
  logic [HIST_AW-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [TBL_W-1:0]   tbl_cnt_q, tbl_cnt_d;
  logic [HIST_DW-1:0] cdf_acc_q, cdf_acc_d;
  logic [HIST_DW-1:0] cdf_sum;

  assign cdf_sum          = cdf_acc_q + hif.ram_rdata;
  assign hif.gen_is_first = 1'b0;
  assign hif.gen_rdata    = hif.ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      run_cnt_q <= '0;
      tbl_cnt_q <= '0;
      cdf_acc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_cnt_q <= run_cnt_d;
      tbl_cnt_q <= tbl_cnt_d;
      cdf_acc_q <= cdf_acc_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    run_cnt_d       = run_cnt_q;
    tbl_cnt_d       = tbl_cnt_q;
    cdf_acc_d       = cdf_acc_q;
    hif.busy        = (state_q != ST_IDLE);
    hif.table_ready = 1'b0;
    hif.gen_start   = 1'b0;
    hif.table_done  = 1'b0;
    hif.hist_valid  = 1'b0;
    hif.hist_bin    = '0;
    hif.hist_count  = '0;
    hif.hist_cdf    = '0;
    hif.frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hif.frame_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Counter wraps back to 0 on the last bin, ready for readout later.
        cnt_d = cnt_q + HIST_AW'(1);
        if (cnt_q == LAST_BIN) state_d = ST_WAIT_TABLE;
      end
      ST_WAIT_TABLE: begin
        if (hif.table_valid) begin
          hif.table_ready = 1'b1;
          hif.gen_start   = 1'b1;
          run_cnt_d       = '0;
          state_d         = ST_RUN_TABLE;
        end
      end
      ST_RUN_TABLE: begin
        run_cnt_d = run_cnt_q + RUN_W'(1);
        if (run_cnt_q == LAST_RUN) begin
          hif.table_done = 1'b1;
          tbl_cnt_d      = tbl_cnt_q + TBL_W'(1);
          state_d        = (tbl_cnt_q == LAST_TBL) ? ST_READOUT : ST_WAIT_TABLE;
        end
      end
      ST_READOUT: begin
        hif.hist_valid = 1'b1;
        hif.hist_bin   = cnt_q;
        hif.hist_count = hif.ram_rdata;
        hif.hist_cdf   = cdf_sum;
        if (hif.hist_ready) begin
          cdf_acc_d = cdf_sum;
          cnt_d     = cnt_q + HIST_AW'(1);
          if (cnt_q == LAST_BIN) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        hif.frame_done = 1'b1;
        cdf_acc_d      = '0;
        cnt_d          = '0;
        tbl_cnt_d      = '0;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  histogram_ram_port_mux #(
    .HIST_AW(HIST_AW),
    .HIST_DW(HIST_DW)
  ) u_port_mux (
    .state_i    (state_q),
    .cnt_i      (cnt_q),
    .gen_addr_i (hif.gen_addr),
    .gen_we_i   (hif.gen_we),
    .gen_wdata_i(hif.gen_wdata),
    .ram_addr_o (hif.ram_addr),
    .ram_we_o   (hif.ram_we),
    .ram_wdata_o(hif.ram_wdata)
  );

endmodule

// File: tb/tb_histogram_frame_controller.sv
module tb_histogram_frame_controller;
  localparam int W     = 16;
  localparam int H     = 8;
  localparam int TS    = 64;
  localparam int NPIX  = W * H;
  localparam int NT    = NPIX / TS;
  localparam int NBINS = 256;
  localparam int AW    = 8;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst;
  logic scramble;
  int   total = 0;
  int   bad   = 0;
  int   gen_tbl = 0;
  logic [7:0]    frame_pix [NPIX];
  logic [DW-1:0] mem [NBINS];

  always #5 clk = ~clk;

  histogram_frame_controller_if #(.HIST_AW(AW), .HIST_DW(DW)) hif();

  histogram_frame_controller #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8), .TABLE_SIZE(TS),
    .HIST_AW(AW), .HIST_DW(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  // Histogram RAM with same-cycle read; scramble fills it with garbage.
  assign hif.ram_rdata = mem[hif.ram_addr];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NBINS; i++) mem[i] <= DW'($urandom_range(0, 255));
    end else if (hif.ram_we) begin
      mem[hif.ram_addr] <= hif.ram_wdata;
    end
  end

  // Histogram generator: per pixel one read cycle then one increment-write cycle.
  initial begin : gen_model
    int base;
    logic [DW-1:0] v;
    hif.gen_addr  = '0;
    hif.gen_we    = 1'b0;
    hif.gen_wdata = '0;
    forever begin
      @(negedge clk);
      hif.gen_we = 1'b0;
      #2;
      if (!hif.busy) gen_tbl = 0;
      if (hif.gen_start) begin
        base = gen_tbl * TS;
        gen_tbl++;
        for (int i = 0; i < TS; i++) begin
          @(negedge clk);
          hif.gen_we   = 1'b0;
          hif.gen_addr = frame_pix[base + i];
          #1 v = hif.gen_rdata;
          @(negedge clk);
          hif.gen_we    = 1'b1;
          hif.gen_wdata = v + DW'(1);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},        32'(hif.busy), 0);
    check({tag, "_table_ready"}, 32'(hif.table_ready), 0);
    check({tag, "_table_done"},  32'(hif.table_done), 0);
    check({tag, "_gen_start"},   32'(hif.gen_start), 0);
    check({tag, "_gen_first"},   32'(hif.gen_is_first), 0);
    check({tag, "_ram_addr"},    32'(hif.ram_addr), 0);
    check({tag, "_ram_we"},      32'(hif.ram_we), 0);
    check({tag, "_ram_wdata"},   32'(hif.ram_wdata), 0);
    check({tag, "_hist_valid"},  32'(hif.hist_valid), 0);
    check({tag, "_hist_bin"},    32'(hif.hist_bin), 0);
    check({tag, "_hist_count"},  32'(hif.hist_count), 0);
    check({tag, "_hist_cdf"},    32'(hif.hist_cdf), 0);
    check({tag, "_frame_done"},  32'(hif.frame_done), 0);
  endtask

  task automatic fill_random(input int maxval);
    for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'($urandom_range(0, maxval));
  endtask

  // stall: 0 = always ready, 1 = toggle, 2 = random
  task automatic run_frame(input bit hold, input int stall, input bit mid_start);
    int exp_cnt [NBINS];
    int guard, last_rdy, nrdy, ndone, acc, b, cyc, last_cdf;
    bit r;
    for (int i = 0; i < NBINS; i++) exp_cnt[i] = 0;
    for (int i = 0; i < NPIX; i++) exp_cnt[frame_pix[i]]++;

    @(negedge clk);
    hif.frame_start = 1'b1;
    #1 check("idle_before_start", 32'(hif.busy), 0);
    guard = 0; last_rdy = -1; nrdy = 0; ndone = 0;
    while (!hif.hist_valid && guard < 3000) begin
      @(negedge clk);
      guard++;
      hif.frame_start = (mid_start && guard == 300);
      hif.table_valid = hold ? 1'b1 : ($urandom_range(0, 2) == 0);
      #1;
      if (guard <= NBINS) begin
        check("clr_we",    32'(hif.ram_we), 1);
        check("clr_addr",  32'(hif.ram_addr), guard - 1);
        check("clr_wdata", 32'(hif.ram_wdata), 0);
      end
      if (hif.table_ready) begin
        check("start_with_ready", 32'(hif.gen_start), 1);
        check("gen_is_first",     32'(hif.gen_is_first), 0);
        if (hold && last_rdy >= 0) check("ready_period", guard - last_rdy, 2 * TS + 1);
        last_rdy = guard;
        nrdy++;
      end
      if (hif.table_done) begin
        check("run_length", guard - last_rdy, 2 * TS);
        ndone++;
      end
      if (mid_start && guard == 300) check("busy_mid_start", 32'(hif.busy), 1);
    end
    hif.table_valid = 1'b0;
    hif.frame_start = 1'b0;
    check("table_phase_timeout", 32'(hif.hist_valid), 1);
    check("tables_accepted", nrdy, NT);
    check("tables_done", ndone, NT);

    acc = 0; b = 0; cyc = 0; last_cdf = -1;
    while (b < NBINS && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      case (stall)
        0:       r = 1'b1;
        1:       r = cyc[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      hif.hist_ready = r;
      #1;
      check("hist_valid", 32'(hif.hist_valid), 1);
      check("hist_bin",   32'(hif.hist_bin), b);
      check("hist_count", 32'(hif.hist_count), exp_cnt[b]);
      check("hist_cdf",   32'(hif.hist_cdf), (acc + exp_cnt[b]) % (1 << DW));
      if (r) begin
        acc += exp_cnt[b];
        last_cdf = 32'(hif.hist_cdf);
        b++;
      end
    end
    check("readout_timeout", b, NBINS);
    check("cdf_total", last_cdf, NPIX);
    @(negedge clk);
    hif.hist_ready = 1'b0;
    #1;
    check("frame_done", 32'(hif.frame_done), 1);
    check("valid_after_last", 32'(hif.hist_valid), 0);
    @(negedge clk);
    #1;
    check("idle_after_frame", 32'(hif.busy), 0);
    check("frame_done_pulse", 32'(hif.frame_done), 0);
  endtask

  initial begin
    rst             = 1'b1;
    scramble        = 1'b1;
    hif.frame_start = 1'b0;
    hif.table_valid = 1'b0;
    hif.hist_ready  = 1'b0;
    repeat (3) @(negedge clk);
    scramble = 1'b0;
    #1 check_quiet("reset");
    check("gen_rdata_pass", 32'(hif.gen_rdata), 32'(mem[hif.ram_addr]));
    rst = 1'b0;
    @(negedge clk);
    #1 check_quiet("idle");

    // Pixel value equals its index: bins 0..127 hold one each.
    for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'(i);
    run_frame(1'b0, 0, 1'b0);

    // Flat frame, continuous table_valid, toggled hist_ready, mid-frame frame_start.
    for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'h80;
    run_frame(1'b1, 1, 1'b1);

    fill_random(255);
    run_frame(1'b0, 2, 1'b0);

    // Abort in the middle of a generator run.
    fill_random(255);
    @(negedge clk);
    hif.frame_start = 1'b1;
    @(negedge clk);
    hif.frame_start = 1'b0;
    hif.table_valid = 1'b1;
    repeat (299) @(negedge clk);
    #1;
    check("abort_busy", 32'(hif.busy), 1);
    check("abort_pass_addr", 32'(hif.ram_addr), 32'(hif.gen_addr));
    check("abort_pass_we", 32'(hif.ram_we), 32'(hif.gen_we));
    rst = 1'b1;
    @(negedge clk);
    #1 check_quiet("abort");
    rst = 1'b0;
    hif.table_valid = 1'b0;
    repeat (150) @(negedge clk);
    #1 check_quiet("abort_idle");

    fill_random(255);
    run_frame(1'b1, 2, 1'b0);

    // Few distinct values: heavy read-modify-write reuse of the same bins.
    fill_random(3);
    run_frame(1'b0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
